// File: rtl/pe_cfg_csr_if.sv
// Host register bus for the PE configuration CSR block.
// Master is the host side, slave is the CSR block.
interface pe_cfg_csr_if #(
  parameter int ADDR_W = 4
);
  logic              reg_write;
  logic [ADDR_W-1:0] reg_addr;
  logic [31:0]       reg_wdata;
  logic [31:0]       reg_rdata;

  modport master (
    output reg_write,
    output reg_addr,
    output reg_wdata,
    input  reg_rdata
  );

  modport slave (
    input  reg_write,
    input  reg_addr,
    input  reg_wdata,
    output reg_rdata
  );
endinterface

// File: rtl/pe_cfg_csr.sv
// Double-buffered PE controller CSR block with job launch/pending/done tracking.
// Optional `PE_CFG_IRQ_EN adds an irq output and an IRQ_MASK register at word 7.
module pe_cfg_csr #(
  parameter int ADDR_W = 4,
  parameter int DIM_W  = 8,
  parameter int KDIM_W = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  pe_cfg_csr_if.slave       bus,
  output logic              start,
  input  logic              done,
  output logic [KDIM_W-1:0] kernel_h,
  output logic [KDIM_W-1:0] kernel_w,
  output logic [DIM_W-1:0]  input_h,
  output logic [DIM_W-1:0]  input_w,
  output logic [DIM_W-1:0]  output_h,
  output logic [DIM_W-1:0]  output_w,
  output logic [3:0]        stride,
  output logic [3:0]        padding
`ifdef PE_CFG_IRQ_EN
  ,
  output logic              irq
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_BUSY
  } state_t;

  state_t r_state, w_nxt;

  logic [KDIM_W-1:0] r_sh_kh, r_sh_kw;
  logic [DIM_W-1:0]  r_sh_ih, r_sh_iw;
  logic [DIM_W-1:0]  r_sh_oh, r_sh_ow;
  logic [3:0]        r_sh_st, r_sh_pd;
  logic [CNT_W-1:0]  r_cycles;
  logic              r_start, r_pending;
  logic              r_done_st, r_err;

  logic        w_wr_ctrl, w_wr_stat;
  logic        w_req, w_clr;
  logic        w_w1c_done, w_w1c_err;
  logic        w_pend_eff, w_pend_nxt;
  logic        w_launch, w_done_hw, w_err_hw;
  logic [31:0] w_rdata;

  assign w_wr_ctrl  = bus.reg_write && (bus.reg_addr == ADDR_W'(0));
  assign w_wr_stat  = bus.reg_write && (bus.reg_addr == ADDR_W'(1));
  assign w_req      = w_wr_ctrl && bus.reg_wdata[0];
  assign w_clr      = w_wr_ctrl && bus.reg_wdata[1];
  assign w_w1c_done = w_wr_stat && bus.reg_wdata[1];
  assign w_w1c_err  = w_wr_stat && bus.reg_wdata[3];
  // soft clear is applied before the start request is evaluated
  assign w_pend_eff = r_pending && !w_clr;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  // next state plus launch/pending/error decisions
  always_comb begin
    w_nxt      = r_state;
    w_launch   = 1'b0;
    w_pend_nxt = w_pend_eff;
    w_done_hw  = 1'b0;
    w_err_hw   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_nxt    = S_LAUNCH;
          w_launch = 1'b1;
        end
      end
      S_LAUNCH: begin
        w_nxt = S_BUSY;
        if (w_req) begin
          if (w_pend_eff) w_err_hw   = 1'b1;
          else            w_pend_nxt = 1'b1;
        end
      end
      S_BUSY: begin
        if (done) begin
          w_done_hw = 1'b1;
          if (w_pend_eff) begin
            w_nxt      = S_LAUNCH;
            w_launch   = 1'b1;
            w_pend_nxt = 1'b0;
            w_err_hw   = w_req;
          end else if (w_req) begin
            w_nxt    = S_LAUNCH;
            w_launch = 1'b1;
          end else begin
            w_nxt = S_IDLE;
          end
        end else if (w_req) begin
          if (w_pend_eff) w_err_hw   = 1'b1;
          else            w_pend_nxt = 1'b1;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // job status flags; hardware set wins over W1C and soft clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start   <= 1'b0;
      r_pending <= 1'b0;
      r_done_st <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_start   <= w_launch;
      r_pending <= w_pend_nxt;
      r_done_st <= w_done_hw ||
                   (r_done_st && !(w_clr || w_w1c_done));
      r_err     <= w_err_hw ||
                   (r_err && !(w_clr || w_w1c_err));
    end
  end

  // shadow config registers written by the host
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_kh <= '0;
      r_sh_kw <= '0;
      r_sh_ih <= '0;
      r_sh_iw <= '0;
      r_sh_oh <= '0;
      r_sh_ow <= '0;
      r_sh_st <= '0;
      r_sh_pd <= '0;
    end else if (bus.reg_write) begin
      case (bus.reg_addr)
        ADDR_W'(2): begin
          r_sh_kw <= bus.reg_wdata[KDIM_W-1:0];
          r_sh_kh <= bus.reg_wdata[8+:KDIM_W];
        end
        ADDR_W'(3): begin
          r_sh_iw <= bus.reg_wdata[DIM_W-1:0];
          r_sh_ih <= bus.reg_wdata[16+:DIM_W];
        end
        ADDR_W'(4): begin
          r_sh_st <= bus.reg_wdata[3:0];
          r_sh_pd <= bus.reg_wdata[7:4];
        end
        ADDR_W'(5): begin
          r_sh_ow <= bus.reg_wdata[DIM_W-1:0];
          r_sh_oh <= bus.reg_wdata[16+:DIM_W];
        end
        default: ;
      endcase
    end
  end

  // active config only moves on launch; old shadow is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kernel_h <= '0;
      kernel_w <= '0;
      input_h  <= '0;
      input_w  <= '0;
      output_h <= '0;
      output_w <= '0;
      stride   <= '0;
      padding  <= '0;
    end else if (w_launch) begin
      kernel_h <= r_sh_kh;
      kernel_w <= r_sh_kw;
      input_h  <= r_sh_ih;
      input_w  <= r_sh_iw;
      output_h <= r_sh_oh;
      output_w <= r_sh_ow;
      stride   <= r_sh_st;
      padding  <= r_sh_pd;
    end
  end

  // job cycle counter, saturating, counts only while BUSY
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycles <= '0;
    end else if (w_launch) begin
      r_cycles <= '0;
    end else if (r_state == S_BUSY &&
                 r_cycles != '1) begin
      r_cycles <= r_cycles + 1'b1;
    end
  end

`ifdef PE_CFG_IRQ_EN
  logic [1:0] r_mask;
  logic       r_irq;

  // irq mask register and registered level irq
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask <= '0;
      r_irq  <= 1'b0;
    end else begin
      if (bus.reg_write &&
          bus.reg_addr == ADDR_W'(7))
        r_mask <= bus.reg_wdata[1:0];
      r_irq <= |(r_mask & {r_err, r_done_st});
    end
  end

  assign irq = r_irq;
`endif

  // combinational read mux; unused bits read 0
  always_comb begin
    w_rdata = '0;
    case (bus.reg_addr)
      ADDR_W'(0): w_rdata[1:0] = {r_pending, r_start};
      ADDR_W'(1): w_rdata[3:0] = {r_err, r_pending,
                                  r_done_st,
                                  r_state != S_IDLE};
      ADDR_W'(2): begin
        w_rdata[KDIM_W-1:0] = r_sh_kw;
        w_rdata[8+:KDIM_W]  = r_sh_kh;
      end
      ADDR_W'(3): begin
        w_rdata[DIM_W-1:0] = r_sh_iw;
        w_rdata[16+:DIM_W] = r_sh_ih;
      end
      ADDR_W'(4): w_rdata[7:0] = {r_sh_pd, r_sh_st};
      ADDR_W'(5): begin
        w_rdata[DIM_W-1:0] = r_sh_ow;
        w_rdata[16+:DIM_W] = r_sh_oh;
      end
      ADDR_W'(6): w_rdata[CNT_W-1:0] = r_cycles;
`ifdef PE_CFG_IRQ_EN
      ADDR_W'(7): w_rdata[1:0] = r_mask;
`endif
      default: ;
    endcase
  end

  assign bus.reg_rdata = w_rdata;
  assign start         = r_start;

endmodule

// File: tb/tb_pe_cfg_csr.sv
// Scoreboard bench for pe_cfg_csr: random and directed register traffic
// against a job-level reference model.
module tb_pe_cfg_csr;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int KW = 4;
  localparam int CW = 4;
  localparam int OBS_W = 1 + 2*KW + 4*DW + 8 + 32 + 1;

  typedef logic [OBS_W-1:0] obs_t;

  logic clk = 1'b0;
  logic rst;
  logic done;
  logic start;
  logic [KW-1:0] kh, kw;
  logic [DW-1:0] ih, iw, oh, ow;
  logic [3:0] st, pd;
  logic irq;

  always #5 clk = ~clk;

  pe_cfg_csr_if #(.ADDR_W(AW)) bus ();

  pe_cfg_csr #(
    .ADDR_W(AW), .DIM_W(DW), .KDIM_W(KW), .CNT_W(CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .start    (start),
    .done     (done),
    .kernel_h (kh),
    .kernel_w (kw),
    .input_h  (ih),
    .input_w  (iw),
    .output_h (oh),
    .output_w (ow),
    .stride   (st),
    .padding  (pd)
`ifdef PE_CFG_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

`ifndef PE_CFG_IRQ_EN
  assign irq = 1'b0;
`endif

  // reference model: job-level view of the block
  bit          m_start, m_run, m_done, m_err, m_irq;
  int          m_q;
  int          m_cyc;
  logic [1:0]  m_mask;
  logic [31:0] sh [8];
  logic [31:0] act [8];

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] fmask(int a);
    logic [31:0] k, d;
    k = (32'd1 << KW) - 1;
    d = (32'd1 << DW) - 1;
    case (a)
      2:       return k | (k << 8);
      3, 5:    return d | (d << 16);
      4:       return 32'hFF;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] mread(int a);
    case (a)
      0: return {30'd0, m_q > 0, m_start};
      1: return {28'd0, m_err, m_q > 0, m_done,
                 m_start | m_run};
      2, 3, 4, 5: return sh[a];
      6: return 32'(m_cyc);
`ifdef PE_CFG_IRQ_EN
      7: return {30'd0, m_mask};
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic obs_t model_obs(int a);
    logic [31:0] k, i, p, o;
    k = act[2]; i = act[3]; p = act[4]; o = act[5];
    return {m_start, k[8+:KW], k[KW-1:0],
            i[16+:DW], i[DW-1:0], o[16+:DW], o[DW-1:0],
            p[3:0], p[7:4], mread(a), m_irq};
  endfunction

  task automatic model_reset();
    m_start = 0; m_run = 0; m_done = 0; m_err = 0;
    m_irq = 0; m_q = 0; m_cyc = 0; m_mask = '0;
    for (int i = 0; i < 8; i++) begin
      sh[i] = '0;
      act[i] = '0;
    end
  endtask

  task automatic model_step(bit wr, int a, logic [31:0] wd, bit dn);
    bit clr, req, w1d, w1e, busy, fin, ns, nr, es;
    int q;
    clr  = wr && a == 0 && wd[1];
    req  = wr && a == 0 && wd[0];
    w1d  = wr && a == 1 && wd[1];
    w1e  = wr && a == 1 && wd[3];
    q    = clr ? 0 : m_q;
    busy = m_start | m_run;
    fin  = m_run && dn;
    ns = 0; es = 0;
    nr = m_run | m_start;
    if (!busy) begin
      ns = req;
    end else if (fin) begin
      nr = 0;
      if (q > 0) begin
        q = q - 1; ns = 1; es = req;
      end else begin
        ns = req;
      end
    end else if (req) begin
      if (q > 0) es = 1;
      else       q = 1;
    end
    if (ns) nr = 0;
`ifdef PE_CFG_IRQ_EN
    m_irq = |(m_mask & {m_err, m_done});
`endif
    if (ns) begin
      m_cyc = 0;
      for (int i = 2; i <= 5; i++) act[i] = sh[i];
    end else if (m_run && m_cyc < (1 << CW) - 1) begin
      m_cyc = m_cyc + 1;
    end
    m_done  = fin | (m_done & !(clr | w1d));
    m_err   = es | (m_err & !(clr | w1e));
    m_q     = q;
    m_start = ns;
    m_run   = nr;
    if (wr && a >= 2 && a <= 5) sh[a] = wd & fmask(a);
`ifdef PE_CFG_IRQ_EN
    if (wr && a == 7) m_mask = wd[1:0];
`endif
  endtask

  // one bus cycle: drive, record expectation, advance model
  task automatic cyc(bit r, bit wr, int a, logic [31:0] wd, bit dn);
    @(posedge clk);
    #1;
    rst = r;
    bus.reg_write = wr;
    bus.reg_addr  = AW'(a);
    bus.reg_wdata = wd;
    done = dn;
    if (r) model_reset();
    exp_q.push_back(model_obs(a));
    if (!r) model_step(wr, a, wd, dn);
  endtask

  task automatic idle(int n, int a);
    for (int i = 0; i < n; i++) cyc(0, 0, a, 32'h0, 0);
  endtask

  // monitor: compares every observed cycle against the queue
  always @(negedge clk) begin
    obs_t e, g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {start, kh, kw, ih, iw, oh, ow, st, pd,
           bus.reg_rdata, irq};
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL obs t=%0t addr=%0d got=%h want=%h",
                 $time, bus.reg_addr, g, e);
      end
    end
  end

  initial begin
    rst = 1'b1;
    done = 1'b0;
    bus.reg_write = 1'b0;
    bus.reg_addr  = '0;
    bus.reg_wdata = '0;
    model_reset();

    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 6, 0, 0);

    // first job with known geometry
    cyc(0, 1, 2, 32'h0303, 0);
    cyc(0, 1, 3, 32'h0010_0010, 0);
    cyc(0, 1, 4, 32'h21, 0);
    cyc(0, 1, 0, 32'h1, 0);
    idle(2, 0);
    cyc(0, 0, 1, 0, 0);
    // shadow write while busy
    cyc(0, 1, 2, 32'h0505, 0);
    cyc(0, 0, 2, 0, 0);
    // two requests during busy: pending then err
    cyc(0, 1, 0, 32'h1, 0);
    cyc(0, 1, 0, 32'h1, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 6, 0, 1);
    idle(3, 6);
    idle(8, 6);
    cyc(0, 0, 6, 0, 1);
    cyc(0, 0, 6, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 1, 32'h2, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 1, 32'h8, 0);
    cyc(0, 0, 1, 0, 0);

    // saturation of the cycle counter
    cyc(0, 1, 7, 32'h1, 0);
    cyc(0, 1, 0, 32'h1, 0);
    idle(20, 6);
    // done with simultaneous W1C: hardware set wins
    cyc(0, 1, 1, 32'h2, 1);
    idle(3, 1);
    cyc(0, 1, 1, 32'h2, 0);
    idle(2, 1);

    // busy + done + request with nothing pending: direct relaunch
    cyc(0, 1, 0, 32'h1, 0);
    idle(3, 0);
    cyc(0, 1, 0, 32'h1, 1);
    idle(2, 1);
    // clear plus request in one write
    cyc(0, 1, 0, 32'h1, 0);
    cyc(0, 1, 0, 32'h1, 0);
    cyc(0, 1, 0, 32'h3, 0);
    cyc(0, 0, 1, 0, 0);
    // busy + done + request with one pending
    cyc(0, 1, 0, 32'h1, 1);
    idle(2, 1);

    // reset mid-busy, then a normal launch
    cyc(0, 1, 5, 32'h0007_0009, 0);
    cyc(0, 1, 0, 32'h1, 0);
    idle(2, 1);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 32'h1, 0);
    idle(3, 0);
    cyc(0, 0, 6, 0, 1);
    idle(2, 1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int a;
      bit wr, dn, r;
      logic [31:0] wd;
      r  = ($urandom_range(0, 299) == 0);
      wr = ($urandom_range(0, 2) == 0);
      dn = ($urandom_range(0, 5) == 0);
      a  = ($urandom_range(0, 9) == 0) ?
           int'($urandom_range(8, 15)) :
           int'($urandom_range(0, 7));
      wd = $urandom();
      if (wr && a == 0 && $urandom_range(0, 1) == 0)
        wd = wd & 32'h1;
      cyc(r, wr, a, wd, dn);
    end

    idle(4, 1);
    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
